// File: rtl/add_pipe_pkg.sv
// Shared definitions for the segmented pipelined adder.
// Segment count helper, configuration check and per-stage control record.
// The width-dependent parts of a stage (partial sum, remaining operand bits)
// are sized per stage inside add_pipe, because their widths differ per stage.
package add_pipe_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic bit cfg_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational W-bit segment adder: {co, s} = a + b + ci.
module add_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  logic [W:0] sum;

  assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
  assign s_o  = sum[W-1:0];
  assign co_o = sum[W];

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit add/subtract, one SEG_W-bit segment resolved per stage.
// Valid/ready on both sides; the whole pipe stalls when the output is held.
// Optional feature macro: ADD_PIPE_OVF_EN adds the signed-overflow output v_o.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
`ifdef ADD_PIPE_OVF_EN
  ,
  output logic             v_o
`endif
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
    $error("add_pipe: WIDTH must be a positive multiple of SEG_W");
  end

  logic adv;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_st
    localparam int SW = (k + 1) * SEG_W;  // resolved low bits after this stage
    localparam int RW = WIDTH - SW;       // operand bits still to be added

    logic [SEG_W-1:0] op_a, op_b, seg_s;
    logic             seg_ci, seg_co, vld_in;
    logic [SW-1:0]    s_d, s_q;
    stage_ctl_t       ctl_d, ctl_q;
    logic             stg_vld, stg_cy;

    if (k == 0) begin : g_src
      assign op_a   = a_i[SEG_W-1:0];
      assign op_b   = b_i[SEG_W-1:0] ^ {SEG_W{sub_i}};
      assign seg_ci = ci_i;
      assign vld_in = in_valid_i;
      assign s_d    = seg_s;
    end else begin : g_src
      assign op_a   = g_st[k-1].g_rem.ra_q[SEG_W-1:0];
      assign op_b   = g_st[k-1].g_rem.rb_q[SEG_W-1:0] ^ {SEG_W{g_st[k-1].g_rem.sub_q}};
      assign seg_ci = g_st[k-1].stg_cy;
      assign vld_in = g_st[k-1].stg_vld;
      assign s_d    = {seg_s, g_st[k-1].s_q};
    end

    add_seg #(.W(SEG_W)) u_seg (
      .a_i  (op_a),
      .b_i  (op_b),
      .ci_i (seg_ci),
      .s_o  (seg_s),
      .co_o (seg_co)
    );

    // Pack the control record for this stage.
    always_comb begin
      ctl_d       = '0;
      ctl_d.valid = vld_in;
      ctl_d.carry = seg_co;
    end

    assign stg_vld = ctl_q.valid;
    assign stg_cy  = ctl_q.carry;

    // Stage register: shift on advance, hold during a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ctl_q <= '0;
        s_q   <= '0;
      end else if (adv) begin
        ctl_q <= ctl_d;
        s_q   <= s_d;
      end
    end

    // Raw upper operand bits and the subtract flag travel to later stages;
    // B is inverted segment by segment as it is consumed.
    if (k < NSEG - 1) begin : g_rem
      logic [RW-1:0] ra_d, rb_d, ra_q, rb_q;
      logic          sub_d, sub_q;

      if (k == 0) begin : g_rsrc
        assign ra_d  = a_i[WIDTH-1:SEG_W];
        assign rb_d  = b_i[WIDTH-1:SEG_W];
        assign sub_d = sub_i;
      end else begin : g_rsrc
        assign ra_d  = g_st[k-1].g_rem.ra_q[RW+SEG_W-1:SEG_W];
        assign rb_d  = g_st[k-1].g_rem.rb_q[RW+SEG_W-1:SEG_W];
        assign sub_d = g_st[k-1].g_rem.sub_q;
      end

      // Remaining-operand register, moves in lockstep with the stage.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ra_q  <= '0;
          rb_q  <= '0;
          sub_q <= 1'b0;
        end else if (adv) begin
          ra_q  <= ra_d;
          rb_q  <= rb_d;
          sub_q <= sub_d;
        end
      end
    end

`ifdef ADD_PIPE_OVF_EN
    if (k == NSEG - 1) begin : g_ovf
      logic v_d, v_q;

      // op_b here is already the effective (possibly inverted) B MSB segment.
      assign v_d = (op_a[SEG_W-1] == op_b[SEG_W-1]) && (seg_s[SEG_W-1] != op_a[SEG_W-1]);

      // Overflow flag registered alongside the final sum.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= v_d;
        end
      end
    end
`endif
  end

  assign out_valid_o = g_st[NSEG-1].stg_vld;
  assign c_o         = g_st[NSEG-1].stg_cy;
  assign s_o         = g_st[NSEG-1].s_q;
`ifdef ADD_PIPE_OVF_EN
  assign v_o         = g_st[NSEG-1].g_ovf.v_q;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Testbench for add_pipe: directed scenarios plus randomized streaming
// against an arithmetic reference model with per-cycle output checking.
module tb_add_pipe;

  localparam int WIDTH = 32;
  localparam int SEG_W = 8;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, s;
  logic             ci, sub, c;
`ifdef ADD_PIPE_OVF_EN
  logic             v;
`endif

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .ci_i        (ci),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .s_o         (s),
    .c_o         (c)
`ifdef ADD_PIPE_OVF_EN
    ,
    .v_o         (v)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    int               idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   adv_cnt = 0;
  int   pop_cnt = 0;
  bit   prev_stall = 0;
  logic [WIDTH-1:0] prev_s;
  logic prev_c;
  bit   exp_valid;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mci, input logic msub);
    exp_t             e;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   sum;
    be    = msub ? ~mb : mb;
    sum   = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, mci};
    e.s   = sum[WIDTH-1:0];
    e.c   = sum[WIDTH];
    e.v   = (ma[WIDTH-1] == be[WIDTH-1]) && (e.s[WIDTH-1] != ma[WIDTH-1]);
    e.idx = 0;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Every op needs NSEG pipe advances (its accept included) to reach the output.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      exp_valid = (q.size() > 0) && ((adv_cnt - q[0].idx) >= NSEG);
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        chk("hold_s", s, prev_s);
        chk("hold_c", c, prev_c);
      end
      if (out_valid && exp_valid) begin
        chk("result_s", s, q[0].s);
        chk("result_c", c, q[0].c);
`ifdef ADD_PIPE_OVF_EN
        chk("result_v", v, q[0].v);
`endif
        if (out_ready) begin
          void'(q.pop_front());
          pop_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      prev_c     = c;
      if (in_valid && in_ready) begin
        exp_t e;
        e     = model(a, b, ci, sub);
        e.idx = adv_cnt;
        q.push_back(e);
      end
      if (in_ready) adv_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 0;
    out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send_and_check(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic tci, input logic tsub,
                                input logic [WIDTH-1:0] es, input logic ec, input logic ev);
    int n;
    drain();
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1;
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_lat"}, n, NSEG);
    chk({name, "_s"}, s, es);
    chk({name, "_c"}, c, ec);
`ifdef ADD_PIPE_OVF_EN
    chk({name, "_v"}, v, ev);
`else
    if (ev === 1'bx) chk({name, "_ev"}, ev, 0);
`endif
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pin;
    logic [WIDTH-1:0] held;
    int pc0;

    rst_n = 0; in_valid = 0; out_ready = 1;
    a = '0; b = '0; ci = 0; sub = 0;

    // Model sanity against hand-computed values
    pin = model('1, '1, 1'b1, 1'b0);
    chk("pin_ones_s", pin.s, 32'hFFFF_FFFF);
    chk("pin_ones_c", pin.c, 1);
    pin = model(32'd5, 32'd7, 1'b1, 1'b1);
    chk("pin_sub_s", pin.s, 32'hFFFF_FFFE);
    chk("pin_sub_c", pin.c, 0);

    // Reset held with input offered
    in_valid = 1; a = 32'd3; b = 32'd4;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_c", c, 0);
    rst_n = 1;
    step();
    in_valid = 0;
    step(); step();
    chk("first_early", out_valid, 0);
    step();
    chk("first_valid", out_valid, 1);
    chk("first_s", s, 32'd7);
    step();

    // Back-to-back streaming, cross-segment carry
    drain();
    a = 32'hFFFF_FFFF; b = 32'd1; ci = 0; sub = 0; in_valid = 1;
    step();
    a = 32'h1234_5678; b = 32'h1111_1111;
    step();
    in_valid = 0;
    step();
    chk("stream_early", out_valid, 0);
    step();
    chk("stream0_valid", out_valid, 1);
    chk("stream0_s", s, 32'h0);
    chk("stream0_c", c, 1);
    step();
    chk("stream1_valid", out_valid, 1);
    chk("stream1_s", s, 32'h2345_6789);
    chk("stream1_c", c, 0);
    step();

    // Subtract and boundary operands
    send_and_check("sub_5_7", 32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0);
    send_and_check("sub_7_5", 32'd7, 32'd5, 1, 1, 32'd2, 1, 0);
    send_and_check("ones_ci", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0);
    send_and_check("zero_m1", 32'd0, 32'd1, 1, 1, 32'hFFFF_FFFF, 0, 0);
    send_and_check("ovf_add", 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 0, 1);
    send_and_check("ovf_sub", 32'h8000_0000, 32'd1, 1, 1, 32'h7FFF_FFFF, 1, 1);

    // Backpressure: fill, stall six cycles, release
    drain();
    out_ready = 0;
    pc0 = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      a = pick(); b = pick(); ci = 1'($urandom); sub = 1'($urandom); in_valid = 1;
      step();
    end
    a = pick(); b = pick();
    chk("bp_full_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    held = s;
    repeat (6) begin
      step();
      chk("bp_in_ready_hold", in_ready, 0);
      chk("bp_s_hold", s, held);
    end
    out_ready = 1;
    step();
    in_valid = 0;
    drain();
    chk("bp_count", pop_cnt - pc0, 5);

    // Asynchronous reset with ops in flight
    drain();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a = pick(); b = pick(); ci = 1'($urandom); sub = 1'($urandom); in_valid = 1;
      step();
    end
    in_valid = 0;
    step();
    chk("mid_valid_before", out_valid, 1);
    #2;
    rst_n = 0;
    q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_c", c, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1;
    out_ready = 1;
    repeat (8) begin
      step();
      chk("mid_no_stale", out_valid, 0);
    end

    // Randomized streaming with random backpressure
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a = pick(); b = pick(); ci = 1'($urandom); sub = 1'($urandom);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
